// File: rtl/ex_muldiv_unit.sv
// ----------------------------------------------------------------------------
// ex_muldiv_unit
// Iterative multiply/divide unit for the EX stage. Signed and unsigned
// multiply (shift-add, one bit per cycle) and restoring divide (one quotient
// bit per cycle) share one set of work registers. Signed operations run on
// operand magnitudes and fix up the result signs at the end.
//
// Optional build macro: EX_MUL_SINGLE_CYCLE_EN
//   defined   -> multiply is combinational, IDLE goes straight to DONE
//   undefined -> multiply iterates XLEN cycles in MUL
//   Division behaves the same in both builds.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush           cancel any in-flight operation (back to IDLE, no done)
//   op_valid, op    request; op 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src1, src2      multiplicand/dividend, multiplier/divisor
//   stall_req       pipeline hold request while a request is taken/busy
//   done            one-cycle completion pulse (with hi_we / lo_we)
//   hi_o, lo_o      upper product/remainder, lower product/quotient
//   div_zero        divide-by-zero flag of the last completed operation
// ----------------------------------------------------------------------------
module ex_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            op_valid,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            stall_req,
    output logic            done,
    output logic            hi_we,
    output logic            lo_we,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o,
    output logic            div_zero
);

    localparam int CW = $clog2(XLEN) + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [XLEN-1:0]   ONE_X    = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [2*XLEN-1:0] ONE_2X   = {{(2*XLEN-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]     CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]     CNT_LAST = CW'(XLEN - 1);

    // Two's-complement negate when en is set (single width)
    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic en);
        if (en) cond_neg = ~v + ONE_X;
        else    cond_neg = v;
    endfunction

    // Two's-complement negate when en is set (double width, products)
    function automatic logic [2*XLEN-1:0] cond_neg2(input logic [2*XLEN-1:0] v, input logic en);
        if (en) cond_neg2 = ~v + ONE_2X;
        else    cond_neg2 = v;
    endfunction

    logic [1:0]      state_r;
    logic [CW-1:0]   cnt_r;
    logic [XLEN-1:0] hi_w_r;     // product high half / partial remainder
    logic [XLEN-1:0] lo_w_r;     // multiplier / dividend shifting into quotient
    logic [XLEN-1:0] dvs_r;      // multiplicand / divisor magnitude
    logic            neg_res_r;  // negate product or quotient at the end
    logic            neg_rem_r;  // remainder follows the dividend sign

    logic            accept_s;
    logic            is_div_s;
    logic            is_signed_s;
    logic            s1_neg_s;
    logic            s2_neg_s;
    logic [XLEN-1:0] a_mag_s;
    logic [XLEN-1:0] b_mag_s;
    logic            dvs_zero_s;
    logic [XLEN:0]   mul_sum_s;
    logic [XLEN:0]   div_trial_s;
    logic [XLEN-1:0] step_hi_s;
    logic [XLEN-1:0] step_lo_s;
    logic [2*XLEN-1:0] prod_fix_s;

    assign accept_s    = (state_r == ST_IDLE) && op_valid && !flush;
    assign is_div_s    = op[1];
    assign is_signed_s = ~op[0];
    assign s1_neg_s    = is_signed_s & src1[XLEN-1];
    assign s2_neg_s    = is_signed_s & src2[XLEN-1];
    assign a_mag_s     = cond_neg(src1, s1_neg_s);
    assign b_mag_s     = cond_neg(src2, s2_neg_s);
    assign dvs_zero_s  = (src2 == {XLEN{1'b0}});

    // Pipeline hold: requested as soon as a request is taken, held while busy
    always_comb begin
        stall_req = 1'b0;
        if (rst) begin
            stall_req = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: stall_req = op_valid && !flush;
                ST_MUL:  stall_req = 1'b1;
                ST_DIV:  stall_req = 1'b1;
                default: stall_req = 1'b0;
            endcase
        end
    end

    assign done  = (state_r == ST_DONE);
    assign hi_we = (state_r == ST_DONE);
    assign lo_we = (state_r == ST_DONE);

    // One iteration of shift-add multiply or restoring divide
    always_comb begin
        mul_sum_s   = {1'b0, hi_w_r} + (lo_w_r[0] ? {1'b0, dvs_r} : {(XLEN+1){1'b0}});
        div_trial_s = {hi_w_r, lo_w_r[XLEN-1]} - {1'b0, dvs_r};
        step_hi_s   = hi_w_r;
        step_lo_s   = lo_w_r;
        if (state_r == ST_MUL) begin
            // {carry, hi, lo} shifted right: low product bits enter lo from the top
            step_hi_s = mul_sum_s[XLEN:1];
            step_lo_s = {mul_sum_s[0], lo_w_r[XLEN-1:1]};
        end else if (div_trial_s[XLEN]) begin
            // trial went negative: restore, quotient bit 0
            step_hi_s = {hi_w_r[XLEN-2:0], lo_w_r[XLEN-1]};
            step_lo_s = {lo_w_r[XLEN-2:0], 1'b0};
        end else begin
            step_hi_s = div_trial_s[XLEN-1:0];
            step_lo_s = {lo_w_r[XLEN-2:0], 1'b1};
        end
        prod_fix_s = cond_neg2({step_hi_s, step_lo_s}, neg_res_r);
    end

`ifdef EX_MUL_SINGLE_CYCLE_EN
    logic [2*XLEN-1:0] fast_prod_s;
    assign fast_prod_s = cond_neg2({{XLEN{1'b0}}, a_mag_s} * {{XLEN{1'b0}}, b_mag_s},
                                   s1_neg_s ^ s2_neg_s);
`endif

    // Control FSM, work registers and registered results
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CW{1'b0}};
            hi_w_r    <= {XLEN{1'b0}};
            lo_w_r    <= {XLEN{1'b0}};
            dvs_r     <= {XLEN{1'b0}};
            neg_res_r <= 1'b0;
            neg_rem_r <= 1'b0;
            hi_o      <= {XLEN{1'b0}};
            lo_o      <= {XLEN{1'b0}};
            div_zero  <= 1'b0;
        end else if (flush) begin
            // results stay as they were; the cancelled operation never reports
            state_r <= ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        cnt_r     <= {CW{1'b0}};
                        neg_res_r <= s1_neg_s ^ s2_neg_s;
                        neg_rem_r <= s1_neg_s;
                        if (is_div_s && dvs_zero_s) begin
                            hi_o     <= src1;
                            lo_o     <= {XLEN{1'b1}};
                            div_zero <= 1'b1;
                            state_r  <= ST_DONE;
                        end else if (is_div_s) begin
                            hi_w_r  <= {XLEN{1'b0}};
                            lo_w_r  <= a_mag_s;
                            dvs_r   <= b_mag_s;
                            state_r <= ST_DIV;
                        end else begin
`ifdef EX_MUL_SINGLE_CYCLE_EN
                            hi_o     <= fast_prod_s[2*XLEN-1:XLEN];
                            lo_o     <= fast_prod_s[XLEN-1:0];
                            div_zero <= 1'b0;
                            state_r  <= ST_DONE;
`else
                            hi_w_r  <= {XLEN{1'b0}};
                            lo_w_r  <= b_mag_s;
                            dvs_r   <= a_mag_s;
                            state_r <= ST_MUL;
`endif
                        end
                    end
                end
                ST_MUL, ST_DIV: begin
                    hi_w_r <= step_hi_s;
                    lo_w_r <= step_lo_s;
                    cnt_r  <= cnt_r + CNT_ONE;
                    if (cnt_r == CNT_LAST) begin
                        div_zero <= 1'b0;
                        state_r  <= ST_DONE;
                        if (state_r == ST_MUL) begin
                            hi_o <= prod_fix_s[2*XLEN-1:XLEN];
                            lo_o <= prod_fix_s[XLEN-1:0];
                        end else begin
                            hi_o <= cond_neg(step_hi_s, neg_rem_r);
                            lo_o <= cond_neg(step_lo_s, neg_res_r);
                        end
                    end
                end
                ST_DONE: state_r <= ST_IDLE;
                default: state_r <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// ----------------------------------------------------------------------------
// tb_ex_muldiv_unit
// Directed self-checking bench for ex_muldiv_unit (XLEN=32). Expected values
// are hand-computed constants. Honours EX_MUL_SINGLE_CYCLE_EN for the
// multiply latency.
// ----------------------------------------------------------------------------
module tb_ex_muldiv_unit;

    localparam int XLEN = 32;
`ifdef EX_MUL_SINGLE_CYCLE_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic            clk;
    logic            rst;
    logic            flush;
    logic            op_valid;
    logic [1:0]      op;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic            stall_req;
    logic            done;
    logic            hi_we;
    logic            lo_we;
    logic [XLEN-1:0] hi_o;
    logic [XLEN-1:0] lo_o;
    logic            div_zero;

    int total_cnt;
    int bad_cnt;
    int done_pulses;
    int we_pulses;

    ex_muldiv_unit #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .op_valid  (op_valid),
        .op        (op),
        .src1      (src1),
        .src2      (src2),
        .stall_req (stall_req),
        .done      (done),
        .hi_we     (hi_we),
        .lo_we     (lo_we),
        .hi_o      (hi_o),
        .lo_o      (lo_o),
        .div_zero  (div_zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pulse counters sampled mid-cycle
    always @(negedge clk) begin
        if (done) done_pulses++;
        if (hi_we || lo_we) we_pulses++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request in the current (IDLE) cycle and wait for done.
    // cyc = cycle index of done (accept cycle is 0), -1 on timeout.
    // serr = number of cycles where stall_req disagreed with expectation.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int cyc, output int serr);
        cyc  = -1;
        serr = 0;
        op       = o;
        src1     = a;
        src2     = b;
        op_valid = 1'b1;
        #1;
        if (stall_req !== 1'b1) serr++;
        tick();
        op_valid = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            if (done) begin
                cyc = n;
                if (stall_req !== 1'b0) serr++;
                break;
            end
            if (stall_req !== 1'b1) serr++;
            tick();
        end
    endtask

    int cyc;
    int serr;
    int dp0;
    int wp0;

    initial begin
        total_cnt   = 0;
        bad_cnt     = 0;
        done_pulses = 0;
        we_pulses   = 0;
        rst      = 1'b1;
        flush    = 1'b0;
        op_valid = 1'b0;
        op       = 2'b00;
        src1     = 32'h0;
        src2     = 32'h0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // reset state
        chk("rst_hi",    {32'h0, hi_o}, 64'h0);
        chk("rst_lo",    {32'h0, lo_o}, 64'h0);
        chk("rst_flags", {59'h0, div_zero, done, hi_we, lo_we, stall_req}, 64'h0);

        // MULT -2 * 3
        run_op(OP_MULT, 32'hFFFF_FFFE, 32'h0000_0003, cyc, serr);
        chk("mult_lat",   64'(cyc), 64'(MUL_LAT));
        chk("mult_hi",    {32'h0, hi_o}, 64'h0000_0000_FFFF_FFFF);
        chk("mult_lo",    {32'h0, lo_o}, 64'h0000_0000_FFFF_FFFA);
        chk("mult_we",    {62'h0, hi_we, lo_we}, 64'h3);
        chk("mult_stall", 64'(serr), 64'h0);
        tick();
        chk("mult_pulse_end", {61'h0, done, hi_we, lo_we}, 64'h0);
        chk("mult_hold_lo",   {32'h0, lo_o}, 64'h0000_0000_FFFF_FFFA);

        // MULT -5 * -7
        run_op(OP_MULT, 32'hFFFF_FFFB, 32'hFFFF_FFF9, cyc, serr);
        chk("mult2_res", {hi_o, lo_o}, 64'h0000_0000_0000_0023);
        tick();

        // MULTU 0xFFFFFFFF * 0xFFFFFFFF
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, serr);
        chk("multu_res", {hi_o, lo_o}, 64'hFFFF_FFFE_0000_0001);
        tick();

        // DIV -7 / 2
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, cyc, serr);
        chk("div_lat",   64'(cyc), 64'(DIV_LAT));
        chk("div_stall", 64'(serr), 64'h0);
        chk("div_res",   {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFD);
        chk("div_dz",    {63'h0, div_zero}, 64'h0);
        tick();

        // DIV 7 / -2
        run_op(OP_DIV, 32'h0000_0007, 32'hFFFF_FFFE, cyc, serr);
        chk("div2_res", {hi_o, lo_o}, 64'h0000_0001_FFFF_FFFD);
        tick();

        // DIVU 100 / 0
        run_op(OP_DIVU, 32'd100, 32'h0, cyc, serr);
        chk("dz_lat", 64'(cyc), 64'd1);
        chk("dz_res", {hi_o, lo_o}, 64'h0000_0064_FFFF_FFFF);
        chk("dz_flag", {63'h0, div_zero}, 64'h1);
        tick();

        // DIV most-negative / -1
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc, serr);
        chk("ovf_lat", 64'(cyc), 64'(DIV_LAT));
        chk("ovf_res", {hi_o, lo_o}, 64'h0000_0000_8000_0000);
        chk("ovf_dz",  {63'h0, div_zero}, 64'h0);
        tick();

        // MULTU result to be retained across a flushed divide
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, serr);
        tick();

        // DIVU 10/3 flushed at cycle 5
        dp0 = done_pulses;
        wp0 = we_pulses;
        op       = OP_DIVU;
        src1     = 32'd10;
        src2     = 32'd3;
        op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        for (int n = 1; n < 5; n++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        chk("flush_idle_stall", {63'h0, stall_req}, 64'h0);
        for (int n = 0; n < 40; n++) tick();
        chk("flush_no_done", 64'(done_pulses - dp0), 64'h0);
        chk("flush_no_we",   64'(we_pulses - wp0), 64'h0);
        chk("flush_hold",    {hi_o, lo_o}, 64'hFFFF_FFFE_0000_0001);

        // back-to-back: second request in the IDLE cycle right after DONE
        run_op(OP_DIVU, 32'd100, 32'd7, cyc, serr);
        chk("b2b_a_res", {hi_o, lo_o}, 64'h0000_0002_0000_000E);
        tick();
        run_op(OP_DIVU, 32'd10, 32'd3, cyc, serr);
        chk("b2b_b_lat",   64'(cyc), 64'(DIV_LAT));
        chk("b2b_b_stall", 64'(serr), 64'h0);
        chk("b2b_b_res",   {hi_o, lo_o}, 64'h0000_0001_0000_0003);
        tick();

        // reset at cycle 10 of a new divide
        op       = OP_DIV;
        src1     = 32'd1000;
        src2     = 32'd7;
        op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        for (int n = 1; n < 10; n++) tick();
        rst = 1'b1;
        tick();
        chk("mrst_res",   {hi_o, lo_o}, 64'h0);
        chk("mrst_flags", {59'h0, div_zero, done, hi_we, lo_we, stall_req}, 64'h0);
        rst = 1'b0;
        for (int n = 0; n < 40; n++) tick();
        chk("mrst_no_done", {61'h0, done, hi_we, lo_we}, 64'h0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
